// File: rtl/vga_rect_writer.sv
// Rectangle-fill pixel writer for the 160x120 VGA adapter: one pixel per clock, raster order.
// Define VGA_RECT_CLIP_EN to suppress pixels that fall outside H_RES x V_RES.
module vga_rect_writer #(
    parameter int unsigned X_W      = 8,
    parameter int unsigned Y_W      = 7,
    parameter int unsigned COLOUR_W = 3,
    parameter int unsigned H_RES    = 160,
    parameter int unsigned V_RES    = 120
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [X_W-1:0]      req_x,
    input  logic [Y_W-1:0]      req_y,
    input  logic [X_W-1:0]      req_w,
    input  logic [Y_W-1:0]      req_h,
    input  logic [COLOUR_W-1:0] req_colour,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic                busy,
    output logic                done
);

`ifdef VGA_RECT_CLIP_EN
    localparam bit ClipEn = 1'b1;
`else
    localparam bit ClipEn = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StDraw, StDone} state_e;

    state_e              state_q, state_d;
    logic [X_W-1:0]      x0_q, x0_d, w_q, w_d, cx_q, cx_d, x_q, x_d;
    logic [Y_W-1:0]      y0_q, y0_d, h_q, h_d, cy_q, cy_d, y_q, y_d;
    logic [COLOUR_W-1:0] col_q, col_d, colour_q, colour_d;
    logic                plot_q, plot_d, busy_q, busy_d, done_q, done_d;

    logic [X_W-1:0]      base_x, off_x;
    logic [Y_W-1:0]      base_y, off_y;
    logic [X_W:0]        sum_x;
    logic [Y_W:0]        sum_y;
    logic                last_col, last_row, in_bounds, draw_pix;

    assign last_col = (cx_q == w_q - X_W'(1));
    assign last_row = (cy_q == h_q - Y_W'(1));

    // Coordinates of the pixel that will be on the outputs after the coming edge.
    always_comb begin
        base_x = x0_q;
        base_y = y0_q;
        off_x  = cx_q + X_W'(1);
        off_y  = cy_q;
        if (state_q == StIdle) begin
            base_x = req_x;
            base_y = req_y;
            off_x  = '0;
            off_y  = '0;
        end else if (last_col) begin
            off_x = '0;
            off_y = cy_q + Y_W'(1);
        end
    end

    assign sum_x     = {1'b0, base_x} + {1'b0, off_x};
    assign sum_y     = {1'b0, base_y} + {1'b0, off_y};
    assign in_bounds = !ClipEn ||
                       ((sum_x < (X_W+1)'(H_RES)) && (sum_y < (Y_W+1)'(V_RES)));

    always_comb begin
        state_d  = state_q;
        x0_d     = x0_q;
        y0_d     = y0_q;
        w_d      = w_q;
        h_d      = h_q;
        col_d    = col_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        plot_d   = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        draw_pix = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    x0_d  = req_x;
                    y0_d  = req_y;
                    w_d   = req_w;
                    h_d   = req_h;
                    col_d = req_colour;
                    cx_d  = '0;
                    cy_d  = '0;
                    if (req_w == '0 || req_h == '0) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = StDraw;
                        draw_pix = 1'b1;
                    end
                end
            end
            StDraw: begin
                if (last_col && last_row) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end else begin
                    cx_d     = off_x;
                    cy_d     = off_y;
                    draw_pix = 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Clipped pixels still consume a cycle but leave x/y/colour untouched.
        if (draw_pix) begin
            busy_d = 1'b1;
            plot_d = in_bounds;
            if (in_bounds) begin
                x_d      = sum_x[X_W-1:0];
                y_d      = sum_y[Y_W-1:0];
                colour_d = col_d;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            x0_q     <= '0;
            y0_q     <= '0;
            w_q      <= '0;
            h_q      <= '0;
            col_q    <= '0;
            cx_q     <= '0;
            cy_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x0_q     <= x0_d;
            y0_q     <= y0_d;
            w_q      <= w_d;
            h_q      <= h_d;
            col_q    <= col_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign req_ready = (state_q == StIdle) && !reset;
    assign x         = x_q;
    assign y         = y_q;
    assign colour    = colour_q;
    assign plot      = plot_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_vga_rect_writer.sv
// Directed bench for vga_rect_writer: table of fill commands plus reset and back-to-back sequences.
module tb_vga_rect_writer;

    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] req_x = '0, req_w = '0;
    logic [6:0] req_y = '0, req_h = '0;
    logic [2:0] req_colour = '0;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot, busy, done;

`ifdef VGA_RECT_CLIP_EN
    localparam bit ClipEn = 1'b1;
`else
    localparam bit ClipEn = 1'b0;
`endif

    vga_rect_writer dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_w     (req_w),
        .req_h     (req_h),
        .req_colour(req_colour),
        .x         (x),
        .y         (y),
        .colour    (colour),
        .plot      (plot),
        .busy      (busy),
        .done      (done)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // plots: hand-counted plot cycles; done_at: cycle of the done pulse after the accepting edge.
    typedef struct {
        int    x0, y0, w, h, col, plots, done_at;
        string name;
    } vec_t;

    vec_t vecs[7];
    int   n_cmp = 0;
    int   n_fail = 0;
    logic [7:0] ex = '0;
    logic [6:0] ey = '0;
    logic [2:0] ec = '0;

    // Observed word: {req_ready, busy, done, plot, x, y, colour}.
    task automatic check(input string name, input logic [21:0] exp, input bit skip_ready);
        logic [21:0] act;
        act = {req_ready, busy, done, plot, x, y, colour};
        if (skip_ready) begin
            act[21] = 1'b0;
            exp[21] = 1'b0;
        end
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got rdy/busy/done/plot=%b x=%0d y=%0d c=%0d, expected %b x=%0d y=%0d c=%0d",
                     name, $time, act[21:18], act[17:10], act[9:3], act[2:0],
                     exp[21:18], exp[17:10], exp[9:3], exp[2:0]);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int wh, cx, cy, sx, sy, seen;
        bit p;
        wh   = v.w * v.h;
        seen = 0;
        req_valid  = 1'b1;
        req_x      = 8'(v.x0);
        req_y      = 7'(v.y0);
        req_w      = 8'(v.w);
        req_h      = 7'(v.h);
        req_colour = 3'(v.col);
        for (int n = 1; n <= v.done_at + 1; n++) begin
            @(posedge CLOCK_50);
            #1;
            if (n == 1) begin
                req_valid  = 1'b0;
                req_x      = 8'hAA;
                req_y      = 7'h55;
                req_w      = 8'd1;
                req_h      = 7'd1;
                req_colour = 3'b010;
            end
            if (plot === 1'b1) seen++;
            if (n <= wh) begin
                cx = (n - 1) % v.w;
                cy = (n - 1) / v.w;
                sx = v.x0 + cx;
                sy = v.y0 + cy;
                p  = !ClipEn || (sx < 160 && sy < 120);
                if (p) begin
                    ex = 8'(sx);
                    ey = 7'(sy);
                    ec = 3'(v.col);
                end
                check(v.name, {1'b0, 1'b1, 1'b0, p, ex, ey, ec}, 1'b0);
            end else if (n == v.done_at) begin
                check(v.name, {1'b0, 1'b0, 1'b1, 1'b0, ex, ey, ec}, 1'b0);
            end else begin
                check(v.name, {1'b1, 1'b0, 1'b0, 1'b0, ex, ey, ec}, 1'b0);
            end
        end
        n_cmp++;
        if (seen != v.plots) begin
            n_fail++;
            $display("FAIL %s plot count: got %0d expected %0d", v.name, seen, v.plots);
        end
    endtask

    initial begin
        vecs[0] = '{5,   7,   1,  1, 4, 1,  2,  "single_pixel"};
        vecs[1] = '{10,  20,  3,  2, 2, 6,  7,  "raster_order"};
        vecs[2] = '{3,   4,   0,  5, 1, 0,  1,  "zero_width"};
        vecs[3] = '{158, 119, 4,  2, 7, ClipEn ? 2 : 8, 9, "clip_edge"};
        vecs[4] = '{254, 126, 3,  3, 1, ClipEn ? 0 : 9, 10, "wrap_corner"};
        vecs[5] = '{50,  60,  5,  0, 5, 0,  1,  "zero_height"};
        vecs[6] = '{0,   0,   12, 3, 6, 36, 37, "wide_fill"};

        #1 reset = 1'b1;
        #2 check("in_reset", 22'b0, 1'b1);
        repeat (2) @(posedge CLOCK_50);
        #1 reset = 1'b0;
        #1 check("reset_state", {1'b1, 21'b0}, 1'b0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset in the middle of a 10x10 fill.
        req_valid = 1'b1; req_x = 8'd0; req_y = 7'd0;
        req_w = 8'd10; req_h = 7'd10; req_colour = 3'd6;
        for (int n = 1; n <= 30; n++) begin
            @(posedge CLOCK_50);
            #1;
            if (n == 1) req_valid = 1'b0;
            ex = 8'((n - 1) % 10);
            ey = 7'((n - 1) / 10);
            ec = 3'd6;
            check("mid_draw", {1'b0, 1'b1, 1'b0, 1'b1, ex, ey, ec}, 1'b0);
        end
        #2 reset = 1'b1;
        #1 check("reset_async", 22'b0, 1'b1);
        ex = '0; ey = '0; ec = '0;
        @(posedge CLOCK_50);
        #1 check("reset_hold", 22'b0, 1'b1);
        reset = 1'b0;
        #1 check("reset_release", {1'b1, 21'b0}, 1'b0);
        for (int n = 0; n < 3; n++) begin
            @(posedge CLOCK_50);
            #1 check("no_done_after_reset", {1'b1, 21'b0}, 1'b0);
        end
        run_vec(vecs[0]);

        // Back-to-back: valid held high, fields switched to command B right after A is taken.
        req_valid = 1'b1; req_x = 8'd20; req_y = 7'd30;
        req_w = 8'd2; req_h = 7'd2; req_colour = 3'd5;
        @(posedge CLOCK_50);
        #1;
        req_x = 8'd40; req_y = 7'd50; req_w = 8'd1; req_h = 7'd2; req_colour = 3'd3;
        check("b2b_a0", {4'b0101, 8'd20, 7'd30, 3'd5}, 1'b0);
        @(posedge CLOCK_50);
        #1 check("b2b_a1", {4'b0101, 8'd21, 7'd30, 3'd5}, 1'b0);
        @(posedge CLOCK_50);
        #1 check("b2b_a2", {4'b0101, 8'd20, 7'd31, 3'd5}, 1'b0);
        @(posedge CLOCK_50);
        #1 check("b2b_a3", {4'b0101, 8'd21, 7'd31, 3'd5}, 1'b0);
        @(posedge CLOCK_50);
        #1 check("b2b_a_done", {4'b0010, 8'd21, 7'd31, 3'd5}, 1'b0);
        @(posedge CLOCK_50);
        #1 check("b2b_ready", {4'b1000, 8'd21, 7'd31, 3'd5}, 1'b0);
        @(posedge CLOCK_50);
        #1 req_valid = 1'b0;
        check("b2b_b0", {4'b0101, 8'd40, 7'd50, 3'd3}, 1'b0);
        @(posedge CLOCK_50);
        #1 check("b2b_b1", {4'b0101, 8'd40, 7'd51, 3'd3}, 1'b0);
        @(posedge CLOCK_50);
        #1 check("b2b_b_done", {4'b0010, 8'd40, 7'd51, 3'd3}, 1'b0);
        @(posedge CLOCK_50);
        #1 check("b2b_idle", {4'b1000, 8'd40, 7'd51, 3'd3}, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
